// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and width helper for the parametrised sync FIFO
package fifo_pkg;

    // Read-data presentation mode, selected at build time through the FWFT parameter.
    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Bits needed to hold values 0..n-1, never less than 1.
    function automatic int clog2_depth(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register-array storage, one synchronous write port, one asynchronous read port
//
// Ports:
//   clk        write clock
//   i_wr_en    write strobe, stores i_wr_data at i_wr_addr on the rising edge
//   i_wr_addr  write address (0..DEPTH-1)
//   i_wr_data  write data
//   i_rd_addr  read address (0..DEPTH-1)
//   o_rd_data  combinational read data at i_rd_addr
module fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    // Contents are deliberately left unreset; pointers and count gate every read.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_pt.sv
// rtl/sync_fifo_pt.sv - single-clock FIFO with thresholds, fill count and optional first-word-fall-through
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en, data_in   write request and data; accepted when not full
//   rd_en            read request; accepted when not empty
//   af_thresh        almostfull  = count >= af_thresh (live, unlatched)
//   ae_thresh        almostempty = count <= ae_thresh (live, unlatched)
//   data_out         FWFT=0: registered word from the last accepted read
//                    FWFT=1: head word while not empty, 0 when empty
//   full, empty      count == FIFO_DEPTH / count == 0
//   wr_ack           registered: previous-cycle write accepted
//   overflow         registered: previous-cycle write refused because full
//   underflow        registered: previous-cycle read refused because empty
//   count            stored entries
module sync_fifo_pt
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int FIFO_DEPTH = 8,
    parameter  int FWFT       = 0,
    localparam int CNT_W      = clog2_depth(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = clog2_depth(FIFO_DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t PTR_LAST = ptr_t'(FIFO_DEPTH - 1);
    localparam cnt_t CNT_FULL = cnt_t'(FIFO_DEPTH);
    localparam fifo_mode_e MODE = fifo_mode_e'(FWFT[0]);

    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_count;
    logic r_wr_ack;
    logic r_overflow;
    logic r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [FIFO_WIDTH-1:0] w_rd_data;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            // Simultaneous accept leaves the count unchanged.
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    generate
        if (MODE == fifo_pkg::FWFT) begin : g_fwft
            // Head word is visible as soon as it is stored; zero while empty.
            assign data_out = w_empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_data_out;

            // Holds across idle and underflow cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rd_data;
                end
            end

            assign data_out = r_data_out;
        end
    endgenerate

    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= af_thresh);
    assign almostempty = (r_count <= ae_thresh);
    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign count       = r_count;

endmodule
